// File: rtl/xdma_dsc_byp_arbiter_if.sv
// Bundle of requester-side and XDMA bypass-side signals for the descriptor-bypass arbiter.
// The arbiter connects through the master modport; user logic / XDMA models use slave.
interface xdma_dsc_byp_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned LEN_W   = 28
);
   localparam int unsigned GW = $clog2(NUM_REQ);

   // Requester side
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_src_addr;
   logic [NUM_REQ*ADDR_W-1:0] req_dst_addr;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ*16-1:0]     req_ctl;
   logic [NUM_REQ-1:0]        req_done;

   // XDMA descriptor-bypass side
   logic                      dsc_byp_load;
   logic [ADDR_W-1:0]         dsc_byp_src_addr;
   logic [ADDR_W-1:0]         dsc_byp_dst_addr;
   logic [LEN_W-1:0]          dsc_byp_len;
   logic [15:0]               dsc_byp_ctl;
   logic                      dsc_byp_ready;

   // Status
   logic [GW-1:0]             grant_id;
   logic                      busy;

   modport master (
      input  req_valid, req_src_addr, req_dst_addr, req_len, req_ctl, dsc_byp_ready,
      output req_ready, req_done, dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr,
             dsc_byp_len, dsc_byp_ctl, grant_id, busy
   );

   modport slave (
      output req_valid, req_src_addr, req_dst_addr, req_len, req_ctl, dsc_byp_ready,
      input  req_ready, req_done, dsc_byp_load, dsc_byp_src_addr, dsc_byp_dst_addr,
             dsc_byp_len, dsc_byp_ctl, grant_id, busy
   );
endinterface

// File: rtl/xdma_dsc_byp_arbiter.sv
// Round-robin descriptor-bypass arbiter for one XDMA channel direction. Accepted descriptors
// are split so that no chunk crosses a 2^CHUNK_LOG2-byte boundary on the host-side address.
module xdma_dsc_byp_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned LEN_W      = 28,
   parameter int unsigned CHUNK_LOG2 = 12,
   parameter bit          DIR_C2H    = 1'b0
) (
   input logic                    axi_aclk,
   input logic                    axi_areset,
   xdma_dsc_byp_arbiter_if.master bus
);
   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam logic [LEN_W:0] ChunkMax = {{LEN_W{1'b0}}, 1'b1} << CHUNK_LOG2;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [LEN_W-1:0]    rem_q;
   logic [15:0]         ctl_q;
   logic [GW-1:0]       grant_q, rr_ptr_q;
   logic [NUM_REQ-1:0]  done_q;

   logic                sel_found;
   logic [GW-1:0]       sel_idx;
   int unsigned         idx;
   logic [ADDR_W-1:0]   sel_src, sel_dst;
   logic [LEN_W-1:0]    sel_len;
   logic [15:0]         sel_ctl;

   logic [CHUNK_LOG2-1:0] host_off;
   logic [LEN_W:0]        room;
   logic                  is_final;
   logic [LEN_W-1:0]      chunk;
   logic                  issue, load;
   logic [NUM_REQ-1:0]    ready_vec, final_vec;

   // Pick the first valid requester at or after rr_ptr, wrapping around
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % NUM_REQ;
         if (!sel_found && bus.req_valid[GW'(idx)]) begin
            sel_found = 1'b1;
            sel_idx   = GW'(idx);
         end
      end
   end

   assign sel_src = bus.req_src_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
   assign sel_dst = bus.req_dst_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
   assign sel_len = bus.req_len[32'(sel_idx)*LEN_W +: LEN_W];
   assign sel_ctl = bus.req_ctl[32'(sel_idx)*16 +: 16];

   // Chunk size: bytes left to the next boundary on the host address, capped by remainder
   always_comb begin
      host_off = DIR_C2H ? dst_q[CHUNK_LOG2-1:0] : src_q[CHUNK_LOG2-1:0];
      room     = ChunkMax - {{(LEN_W+1-CHUNK_LOG2){1'b0}}, host_off};
      is_final = ({1'b0, rem_q} <= room);
      // room never exceeds 2^CHUNK_LOG2 < 2^LEN_W, so the low bits hold it exactly
      chunk    = is_final ? rem_q : room[LEN_W-1:0];
   end

   assign issue = (state_q == StIssue);
   assign load  = issue & bus.dsc_byp_ready;

   // Combinational one-hot accept and final-chunk done vectors
   always_comb begin
      ready_vec = '0;
      final_vec = '0;
      if (!issue && sel_found && !axi_areset) ready_vec[sel_idx] = 1'b1;
      if (load && is_final) final_vec[grant_q] = 1'b1;
   end

   assign bus.req_ready        = ready_vec;
   assign bus.req_done         = done_q | final_vec;
   assign bus.dsc_byp_load     = load;
   assign bus.dsc_byp_src_addr = src_q;
   assign bus.dsc_byp_dst_addr = dst_q;
   assign bus.dsc_byp_len      = issue ? chunk : '0;
   // Stop/completed/EOP belong only on the last chunk of a descriptor
   assign bus.dsc_byp_ctl      = !issue ? '0 : (is_final ? ctl_q : (ctl_q & ~16'h0013));
   assign bus.grant_id         = grant_q;
   assign bus.busy             = issue;

   // Arbitration / issue state machine
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q  <= StIdle;
         src_q    <= '0;
         dst_q    <= '0;
         rem_q    <= '0;
         ctl_q    <= '0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         done_q   <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (sel_found) begin
                  grant_q  <= sel_idx;
                  rr_ptr_q <= (sel_idx == GW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                  src_q    <= sel_src;
                  dst_q    <= sel_dst;
                  rem_q    <= sel_len;
                  ctl_q    <= sel_ctl;
                  // Zero-length descriptors complete without touching the bypass port
                  if (sel_len == '0) done_q[sel_idx] <= 1'b1;
                  else               state_q         <= StIssue;
               end
            end
            StIssue: begin
               if (bus.dsc_byp_ready) begin
                  src_q <= src_q + ADDR_W'(chunk);
                  dst_q <= dst_q + ADDR_W'(chunk);
                  rem_q <= rem_q - chunk;
                  if (is_final) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_xdma_dsc_byp_arbiter.sv
// Randomized bench for xdma_dsc_byp_arbiter against a descriptor-level reference model.
module tb_xdma_dsc_byp_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 64;
   localparam int unsigned LW = 28;
   localparam int unsigned CL = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xdma_dsc_byp_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW)) bus_h ();
   xdma_dsc_byp_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW)) bus_c ();

   xdma_dsc_byp_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .CHUNK_LOG2(CL), .DIR_C2H(1'b0)
   ) dut_h (
      .axi_aclk  (clk),
      .axi_areset(rst),
      .bus       (bus_h)
   );

   xdma_dsc_byp_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .CHUNK_LOG2(CL), .DIR_C2H(1'b1)
   ) dut_c (
      .axi_aclk  (clk),
      .axi_areset(rst),
      .bus       (bus_c)
   );

   typedef struct {
      logic [63:0] src;
      logic [63:0] dst;
      logic [27:0] len;
      logic [15:0] ctl;
      bit          fin;
   } chunk_t;

   chunk_t exp_h[$];
   chunk_t exp_c[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Requester stimulus (H2C instance)
   bit          pend[N];
   logic [63:0] r_src[N];
   logic [63:0] r_dst[N];
   logic [27:0] r_len[N];
   logic [15:0] r_ctl[N];
   bit          rdy;
   bit          rand_mode;
   logic [N-1:0] refill;

   // Reference model state
   int          m_rr;
   int          m_gid;
   logic [N-1:0] m_done;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Split a descriptor into expected chunks straight from the boundary rule
   task automatic build(bit dir, logic [63:0] src, logic [63:0] dst, logic [27:0] len,
                        logic [15:0] ctl);
      logic [63:0]     s, d, host;
      longint unsigned rem, room, c;
      chunk_t          ch;
      s   = src;
      d   = dst;
      rem = longint'(len);
      while (rem > 0) begin
         host   = dir ? d : s;
         room   = (64'd1 << CL) - (host % (64'd1 << CL));
         c      = (rem < room) ? rem : room;
         ch.src = s;
         ch.dst = d;
         ch.len = 28'(c);
         ch.fin = (c == rem);
         ch.ctl = ch.fin ? ctl : (ctl & ~16'h0013);
         if (dir) exp_c.push_back(ch);
         else     exp_h.push_back(ch);
         s   = s + c;
         d   = d + c;
         rem = rem - c;
      end
   endtask

   task automatic set_req(int i, logic [63:0] s, logic [63:0] d, logic [27:0] l,
                          logic [15:0] c);
      pend[i]  = 1'b1;
      r_src[i] = s;
      r_dst[i] = d;
      r_len[i] = l;
      r_ctl[i] = c;
   endtask

   task automatic gen_rand(int i);
      logic [63:0] s, d;
      logic [27:0] l;
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      if ($urandom_range(1) == 0) s[11:8] = 4'hF;
      if ($urandom_range(15) == 0) s = 64'hFFFF_FFFF_FFFF_FF80;
      case ($urandom_range(4))
         0:       l = 28'd0;
         1:       l = 28'($urandom_range(1, 64));
         2:       l = 28'($urandom_range(1, 32'h2400));
         3:       l = 28'h1000;
         default: l = 28'($urandom_range(1, 256));
      endcase
      set_req(i, s, d, l, 16'($urandom));
   endtask

   task automatic drive_h();
      for (int i = 0; i < N; i++) begin
         bus_h.req_valid[i]           = pend[i];
         bus_h.req_src_addr[i*AW +: AW] = r_src[i];
         bus_h.req_dst_addr[i*AW +: AW] = r_dst[i];
         bus_h.req_len[i*LW +: LW]      = r_len[i];
         bus_h.req_ctl[i*16 +: 16]      = r_ctl[i];
      end
      bus_h.dsc_byp_ready = rdy;
   endtask

   // One clock cycle: drive at negedge, check, advance the model past the next posedge
   task automatic step();
      int           sel;
      logic [N-1:0] exp_ready, exp_done;
      bit           busy_e, load_e;
      chunk_t       h;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(3) == 0) gen_rand(i);
         rdy = ($urandom_range(3) != 0);
      end
      for (int i = 0; i < N; i++)
         if (refill[i] && !pend[i]) set_req(i, {32'h0, $urandom}, 64'h0, 28'h40, 16'h0013);
      drive_h();
      #1;
      sel    = -1;
      busy_e = (exp_h.size() > 0);
      if (!busy_e)
         for (int k = 0; k < N; k++)
            if (sel < 0 && pend[(m_rr + k) % N]) sel = (m_rr + k) % N;
      exp_ready = '0;
      if (sel >= 0) exp_ready[sel] = 1'b1;
      load_e   = busy_e && rdy;
      exp_done = m_done;
      if (busy_e) h = exp_h[0];
      if (load_e && h.fin) exp_done[m_gid] = 1'b1;
      check("req_ready", bus_h.req_ready, exp_ready);
      check("req_done", bus_h.req_done, exp_done);
      check("load", bus_h.dsc_byp_load, load_e);
      check("busy", bus_h.busy, busy_e);
      check("grant_id", bus_h.grant_id, m_gid);
      if (busy_e) begin
         check("len", bus_h.dsc_byp_len, h.len);
         check("ctl", bus_h.dsc_byp_ctl, h.ctl);
         check("src", bus_h.dsc_byp_src_addr, h.src);
         check("dst", bus_h.dsc_byp_dst_addr, h.dst);
      end
      m_done = '0;
      if (load_e) void'(exp_h.pop_front());
      if (sel >= 0) begin
         pend[sel] = 1'b0;
         m_rr      = (sel + 1) % N;
         m_gid     = sel;
         if (r_len[sel] == 0) m_done[sel] = 1'b1;
         else build(1'b0, r_src[sel], r_dst[sel], r_len[sel], r_ctl[sel]);
      end
      @(negedge clk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Directed C2H split on the second instance: boundary follows dst
   task automatic c2h_test();
      chunk_t h;
      bus_c.req_valid                 = 4'b0010;
      bus_c.req_src_addr[1*AW +: AW] = 64'h0000_0000_5000_0123;
      bus_c.req_dst_addr[1*AW +: AW] = 64'h0;
      bus_c.req_len[1*LW +: LW]      = 28'h2800;
      bus_c.req_ctl[1*16 +: 16]      = 16'h0013;
      bus_c.dsc_byp_ready            = 1'b1;
      build(1'b1, 64'h0000_0000_5000_0123, 64'h0, 28'h2800, 16'h0013);
      #1;
      check("c2h_ready", bus_c.req_ready, 4'b0010);
      @(negedge clk);
      bus_c.req_valid = '0;
      while (exp_c.size() > 0) begin
         h = exp_c.pop_front();
         #1;
         check("c2h_load", bus_c.dsc_byp_load, 1'b1);
         check("c2h_len", bus_c.dsc_byp_len, h.len);
         check("c2h_src", bus_c.dsc_byp_src_addr, h.src);
         check("c2h_dst", bus_c.dsc_byp_dst_addr, h.dst);
         check("c2h_ctl", bus_c.dsc_byp_ctl, h.ctl);
         check("c2h_done", bus_c.req_done, h.fin ? 4'b0010 : 4'b0000);
         @(negedge clk);
      end
      #1;
      check("c2h_busy_end", bus_c.busy, 1'b0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(string pfx);
      check({pfx, "_load"}, bus_h.dsc_byp_load, 1'b0);
      check({pfx, "_busy"}, bus_h.busy, 1'b0);
      check({pfx, "_ready"}, bus_h.req_ready, 4'b0);
      check({pfx, "_done"}, bus_h.req_done, 4'b0);
      check({pfx, "_len"}, bus_h.dsc_byp_len, 28'h0);
      check({pfx, "_ctl"}, bus_h.dsc_byp_ctl, 16'h0);
      check({pfx, "_src"}, bus_h.dsc_byp_src_addr, 64'h0);
      check({pfx, "_dst"}, bus_h.dsc_byp_dst_addr, 64'h0);
      check({pfx, "_gid"}, bus_h.grant_id, 2'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) set_req(i, 64'h0, 64'h0, 28'h0, 16'h0);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      rdy       = 1'b1;
      rand_mode = 1'b0;
      refill    = '0;
      m_rr      = 0;
      m_gid     = 0;
      m_done    = '0;
      drive_h();
      bus_c.req_valid     = '0;
      bus_c.req_src_addr  = '0;
      bus_c.req_dst_addr  = '0;
      bus_c.req_len       = '0;
      bus_c.req_ctl       = '0;
      bus_c.dsc_byp_ready = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      @(negedge clk);

      c2h_test();

      // Single chunk, then a split across a 4 KiB boundary
      set_req(0, 64'h1000_0000, 64'h40, 28'h80, 16'h0013);
      run(4);
      set_req(0, 64'h1000_0F00, 64'h2000, 28'h300, 16'h0013);
      run(5);

      // Round-robin among continuously valid requesters 0, 1, 3
      refill = 4'b1011;
      run(14);
      refill = '0;
      run(6);

      // Backpressure mid-descriptor, then a zero-length request on req2
      set_req(1, 64'h2000_0800, 64'h9000, 28'h1800, 16'h0011);
      run(1);
      rdy = 1'b0;
      run(5);
      rdy = 1'b1;
      run(4);
      set_req(2, 64'h3000_0000, 64'h0, 28'h0, 16'h0013);
      run(3);

      // Randomized traffic and backpressure
      rand_mode = 1'b1;
      run(1500);
      rand_mode = 1'b0;
      rdy       = 1'b1;
      run(300);

      // Reset during the second of three chunks
      set_req(0, 64'h0000_0000_3000_0F00, 64'h0, 28'h2000, 16'h0013);
      run(2);
      rdy = 1'b0;
      run(1);
      drive_h();
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_h.delete();
      m_rr   = 0;
      m_gid  = 0;
      m_done = '0;
      @(posedge clk);
      #1;
      check("midrst_noload", bus_h.dsc_byp_load, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rdy = 1'b1;
      set_req(1, 64'h4000_0000, 64'h100, 28'h80, 16'h0013);
      set_req(3, 64'h5000_0000, 64'h200, 28'h80, 16'h0013);
      run(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
